game_flow_ctrl: RTL and testbench

Parametrised game-flow state machine that sequences start, play, level advance, world advance, life loss, game over and game win. It sits beside the player/scroll/obstacle blocks in the top-level game, consumes the per-level player status and start button, and drives game_status, world, level and lives to the video, scroll and obstacle logic. It generalises the fixed three-bit world/level FSM to configurable world count, levels per world, lives and banner hold time.

---
 rtl/game_flow_pkg.sv | 31 +++
 rtl/game_flow_ctrl_banner_timer.sv | 26 ++
 rtl/game_flow_ctrl.sv | 128 ++++++++++++
 tb/tb_game_flow_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/game_flow_pkg.sv
// Shared encodings for the game-flow controller: game_status codes, player_status
// codes and the FSM state type whose values are the game_status codes themselves.
package game_flow_pkg;

  localparam logic [2:0] ST_START     = 3'd0;
  localparam logic [2:0] ST_PLAYING   = 3'd1;
  localparam logic [2:0] ST_LEVEL_INC = 3'd2;
  localparam logic [2:0] ST_WORLD_INC = 3'd3;
  localparam logic [2:0] ST_LIFE_LOST = 3'd4;
  localparam logic [2:0] ST_LOSE      = 3'd5;
  localparam logic [2:0] ST_WIN       = 3'd6;

  localparam logic [1:0] PS_PLAYING = 2'd0;
  localparam logic [1:0] PS_PASS    = 2'd1;
  localparam logic [1:0] PS_DIED    = 2'd2;

  typedef enum logic [2:0] {
    S_START     = ST_START,
    S_PLAYING   = ST_PLAYING,
    S_LEVEL_INC = ST_LEVEL_INC,
    S_WORLD_INC = ST_WORLD_INC,
    S_LIFE_LOST = ST_LIFE_LOST,
    S_LOSE      = ST_LOSE,
    S_WIN       = ST_WIN
  } state_e;

  function automatic logic isBanner(input state_e s);
    return (s == S_LEVEL_INC) || (s == S_WORLD_INC) || (s == S_LIFE_LOST);
  endfunction

endpackage

// File: rtl/game_flow_ctrl_banner_timer.sv
// Banner hold timer: counts from 0 up to BANNER_CYCLES-1 while enabled and then
// holds there, so done stays high until the owner clears it.
module banner_timer #(
  parameter int BANNER_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = $clog2(BANNER_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BANNER_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (clear)            cnt <= '0;
    else if (enable && !done)  cnt <= cnt + CNT_W'(1);
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer: start, play, level/world advance, life loss, lose and win.
// Define EXTRA_LIFE_EN to award a saturating extra life on every world advance.
module game_flow_ctrl
  import game_flow_pkg::*;
#(
  parameter int NUM_WORLDS       = 4,
  parameter int LEVELS_PER_WORLD = 6,
  parameter int START_LIVES      = 3,
  parameter int MAX_LIVES        = 9,
  parameter int BANNER_CYCLES    = 100000000,
  parameter int WORLD_W          = 2,
  parameter int LEVEL_W          = 3,
  parameter int LIVES_W          = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic [1:0]         player_status,
  output logic [2:0]         game_status,
  output logic [WORLD_W-1:0] world,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic               level_load,
  output logic               banner_active
);

  localparam logic [WORLD_W-1:0] LAST_WORLD = WORLD_W'(NUM_WORLDS - 1);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(LEVELS_PER_WORLD - 1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_CAP  = LIVES_W'(MAX_LIVES);

  state_e             state, nextState;
  logic [WORLD_W-1:0] worldNext;
  logic [LEVEL_W-1:0] levelNext;
  logic [LIVES_W-1:0] livesNext;
  logic               startPrev, startRise, bannerDone, inBanner;

  assign startRise = start_btn & ~startPrev;
  assign inBanner  = isBanner(state);

  // Timer is held cleared outside banner states, so every banner entry starts at 0.
  banner_timer #(.BANNER_CYCLES(BANNER_CYCLES)) uTimer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!inBanner),
    .enable (inBanner),
    .done   (bannerDone)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_START;
      world      <= '0;
      level      <= '0;
      lives      <= LIVES_INIT;
      level_load <= 1'b0;
      startPrev  <= 1'b0;
    end else begin
      state      <= nextState;
      world      <= worldNext;
      level      <= levelNext;
      lives      <= livesNext;
      level_load <= (nextState == S_PLAYING) && (state != S_PLAYING);
      startPrev  <= start_btn;
    end
  end

  always_comb begin
    nextState = state;
    worldNext = world;
    levelNext = level;
    livesNext = lives;
    case (state)
      S_START: begin
        if (startRise) begin
          nextState = S_PLAYING;
          worldNext = '0;
          levelNext = '0;
          livesNext = LIVES_INIT;
        end
      end
      S_PLAYING: begin
        case (player_status)
          PS_PASS: begin
            if (level != LAST_LEVEL) begin
              nextState = S_LEVEL_INC;
              levelNext = level + LEVEL_W'(1);
            end else if (world == LAST_WORLD) begin
              nextState = S_WIN;
            end else begin
              nextState = S_WORLD_INC;
              worldNext = world + WORLD_W'(1);
              levelNext = '0;
`ifdef EXTRA_LIFE_EN
              if (lives < LIVES_CAP) livesNext = lives + LIVES_W'(1);
`else
              livesNext = lives;
`endif
            end
          end
          PS_DIED: begin
            // <=1 rather than ==1 keeps the counter from ever underflowing.
            if (lives <= LIVES_W'(1)) begin
              nextState = S_LOSE;
              livesNext = '0;
            end else begin
              nextState = S_LIFE_LOST;
              livesNext = lives - LIVES_W'(1);
            end
          end
          default: ;
        endcase
      end
      S_LEVEL_INC, S_WORLD_INC, S_LIFE_LOST: begin
        // Wait for downstream to drop its status flag before resuming play.
        if (bannerDone && (player_status == PS_PLAYING)) nextState = S_PLAYING;
      end
      S_LOSE, S_WIN: begin
        if (startRise) nextState = S_START;
      end
      default: nextState = S_START;
    endcase
  end

  assign game_status   = state;
  assign banner_active = inBanner;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Randomized bench for game_flow_ctrl against a rule-level model of the game flow.
module tb_game_flow_ctrl;

  localparam int NW = 2, NL = 3, SL = 3, ML = 9, BC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic [1:0] ps  = 2'd0;
  logic [2:0] gameStatus;
  logic [1:0] worldQ;
  logic [2:0] levelQ;
  logic [3:0] livesQ;
  logic       levelLoad, bannerActive;

  game_flow_ctrl #(
    .NUM_WORLDS(NW), .LEVELS_PER_WORLD(NL), .START_LIVES(SL), .MAX_LIVES(ML),
    .BANNER_CYCLES(BC), .WORLD_W(2), .LEVEL_W(3), .LIVES_W(4)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(btn), .player_status(ps),
    .game_status(gameStatus), .world(worldQ), .level(levelQ), .lives(livesQ),
    .level_load(levelLoad), .banner_active(bannerActive)
  );

  always #5 clk = ~clk;

  int nVec = 0, nErr = 0, cyc = 0;

  // Model: phase is the game_status code; bannerLeft counts cycles still to hold.
  int mPhase, mWorld, mLevel, mLives, mBannerLeft;
  bit mLoad, mPrevBtn;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    mPhase = 0; mWorld = 0; mLevel = 0; mLives = SL;
    mBannerLeft = 0; mLoad = 0; mPrevBtn = 0;
  endtask

  task automatic modelStep();
    bit rise;
    if (!rst) begin modelReset(); return; end
    rise = btn && !mPrevBtn;
    mPrevBtn = btn;
    mLoad = 0;
    case (mPhase)
      0: if (rise) begin
           mPhase = 1; mWorld = 0; mLevel = 0; mLives = SL; mLoad = 1;
         end
      1: begin
           if (ps == 2'd1) begin
             if (mLevel < NL - 1) begin
               mLevel++; mPhase = 2;
             end else if (mWorld == NW - 1) begin
               mPhase = 6;
             end else begin
               mWorld++; mLevel = 0; mPhase = 3;
`ifdef EXTRA_LIFE_EN
               mLives = (mLives + 1 > ML) ? ML : mLives + 1;
`endif
             end
           end else if (ps == 2'd2) begin
             if (mLives == 1) begin mLives = 0; mPhase = 5; end
             else begin mLives--; mPhase = 4; end
           end
           if (mPhase inside {2, 3, 4}) mBannerLeft = BC - 1;
         end
      2, 3, 4: begin
           if (mBannerLeft == 0 && ps == 2'd0) begin mPhase = 1; mLoad = 1; end
           else if (mBannerLeft > 0) mBannerLeft--;
         end
      default: if (rise) mPhase = 0;
    endcase
  endtask

  task automatic checkAll();
    chk("status", 32'(gameStatus), 32'(mPhase));
    chk("world",  32'(worldQ),     32'(mWorld));
    chk("level",  32'(levelQ),     32'(mLevel));
    chk("lives",  32'(livesQ),     32'(mLives));
    chk("load",   32'(levelLoad),  32'(mLoad));
    chk("banner", 32'(bannerActive), 32'(mPhase inside {2, 3, 4}));
  endtask

  // One clock: model advances on the edge, DUT compared 1ns later.
  task automatic tick();
    @(posedge clk);
    cyc++;
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic run(input logic b, input logic [1:0] s, input int n);
    btn = b; ps = s;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic midReset();
    #2 rst = 1'b0;
    #1;
    modelReset();
    checkAll();
  endtask

  initial begin
    modelReset();
    run(0, 0, 3);
    rst = 1'b1;
    run(0, 0, 2);
    run(1, 0, 4);                       // start -> PLAYING with one load pulse
    run(1, 1, 2); run(1, 0, 8);         // level 0 -> 1, status cleared early
    run(1, 1, 10); run(1, 0, 3);        // status held past banner end
    run(1, 1, 2); run(1, 0, 8);         // level 2 world 0 -> WORLD_INC
    for (int d = 0; d < 3; d++) begin   // deaths down to LOSE
      run(1, 2, 2); run(1, 0, 6);
    end
    run(0, 0, 1); run(1, 0, 1);         // start_rise out of LOSE
    run(0, 0, 1); run(1, 0, 2);         // back into PLAYING
    for (int p = 0; p < 6; p++) begin   // clear every level to WIN
      run(1, 1, 2); run(1, 0, 7);
    end
    run(0, 0, 1); run(1, 0, 1);         // WIN -> START
    run(0, 0, 1); run(1, 0, 2);
    run(1, 1, 2);                       // into LEVEL_INC banner
    midReset();
    run(1, 0, 3);
    rst = 1'b1;
    run(0, 0, 2);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 25) btn = ~btn;
      if ($urandom_range(99) < 30) begin
        case ($urandom_range(19))
          0, 1, 2, 3, 4, 5, 6, 7, 8, 9: ps = 2'd0;
          10, 11, 12, 13:               ps = 2'd1;
          14, 15, 16:                   ps = 2'd2;
          default:                      ps = 2'd3;
        endcase
      end
      if ($urandom_range(599) == 0) begin
        midReset();
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
